// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory request/grant/response bus between mem_stage and memory
//  master (mem_stage): req, we, addr (word aligned), wdata (lane replicated), be
//  slave  (memory):    gnt (request accepted), rvalid (load data valid), rdata
interface mem_stage_if #(parameter int XLEN = 32);
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [3:0]      be;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;
  modport master(output req, we, addr, wdata, be, input gnt, rvalid, rdata);
  modport slave(input req, we, addr, wdata, be, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between execute and writeback, one dmem transaction per op
//  clk, rst_n : clock, async active-low reset
//  E_*        : op from execute (valid/ready), ALU result/address, store data, size, rd, PC
//  dmem       : data-memory bus (master side)
//  M_*        : result to writeback (valid/ready), extended load data or passed-through result,
//               rd/write enable, PC, exception flag (misaligned/illegal memory access)
module mem_stage #(
  parameter int XLEN     = 32,
  parameter int PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                E_valid_i,
  output logic                E_ready_o,
  input  logic [XLEN-1:0]     E_valE_i,
  input  logic [XLEN-1:0]     E_store_data_i,
  input  logic                E_load_i,
  input  logic                E_store_i,
  input  logic [2:0]          E_funct3_i,
  input  logic [4:0]          E_rd_i,
  input  logic                E_rd_wen_i,
  input  logic [PC_WIDTH-1:0] E_PC_i,
  mem_stage_if.master         dmem,
  output logic                M_valid_o,
  input  logic                M_ready_i,
  output logic [XLEN-1:0]     M_valM_o,
  output logic [4:0]          M_rd_o,
  output logic                M_rd_wen_o,
  output logic [PC_WIDTH-1:0] M_PC_o,
  output logic                M_exc_o
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic [XLEN-1:0] addr_q, data_q, val_q, ld_val;
  logic [PC_WIDTH-1:0] pc_q;
  logic [4:0] rd_q;
  logic [2:0] f3_q;
  logic [1:0] off;
  logic [7:0] lbyte;
  logic [15:0] lhalf;
  logic [3:0] be_st;
  logic store_q, wen_q, exc_q, accept, is_mem, bad_f3, mis, exc_in, req, we;
  assign E_ready_o = state == IDLE || (state == DONE && M_ready_i);
  assign accept    = E_valid_i & E_ready_o;
  assign is_mem    = E_load_i | E_store_i;
  // loads allow b/h/w/bu/hu; stores allow only b/h/w
  assign bad_f3 = E_store_i ? (E_funct3_i[2] || E_funct3_i[1:0] == 2'b11)
                            : (E_funct3_i[1:0] == 2'b11 || E_funct3_i == 3'b110);
  assign mis = (E_funct3_i[1:0] == 2'b01 && E_valE_i[0]) ||
               (E_funct3_i[1:0] == 2'b10 && E_valE_i[1:0] != 2'b00);
  assign exc_in = is_mem & ((E_load_i & E_store_i) | bad_f3 | mis);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_comb begin
    state_nx = state;
    if (accept) state_nx = (is_mem && !exc_in) ? REQ : DONE;
    else if (state == REQ && dmem.gnt) state_nx = store_q ? DONE : WAIT;
    else if (state == WAIT && dmem.rvalid) state_nx = DONE;
    else if (state == DONE && M_ready_i) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr_q  <= '0;
      data_q  <= '0;
      val_q   <= '0;
      pc_q    <= '0;
      rd_q    <= '0;
      f3_q    <= '0;
      store_q <= 1'b0;
      wen_q   <= 1'b0;
      exc_q   <= 1'b0;
    end else if (accept) begin
      addr_q  <= E_valE_i;
      data_q  <= E_store_data_i;
      val_q   <= E_valE_i;
      pc_q    <= E_PC_i;
      rd_q    <= E_rd_i;
      f3_q    <= E_funct3_i;
      store_q <= E_store_i;
      wen_q   <= E_rd_wen_i & ~E_store_i & ~exc_in;
      exc_q   <= exc_in;
    end else if (state == WAIT && dmem.rvalid) begin
      val_q <= ld_val;
    end
  assign off   = addr_q[1:0];
  assign lbyte = dmem.rdata[{off, 3'b000} +: 8];
  assign lhalf = off[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
  // funct3[2] selects zero extension for lbu/lhu
  assign ld_val = f3_q[1] ? dmem.rdata
                : f3_q[0] ? {{(XLEN-16){~f3_q[2] & lhalf[15]}}, lhalf}
                          : {{(XLEN-8){~f3_q[2] & lbyte[7]}}, lbyte};
  assign be_st = f3_q[1] ? 4'b1111 : f3_q[0] ? 4'b0011 << off : 4'b0001 << off;
  assign req          = state == REQ;
  assign we           = req & store_q;
  assign dmem.req     = req;
  assign dmem.we      = we;
  assign dmem.addr    = req ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign dmem.be      = we ? be_st : 4'b0000;
  assign dmem.wdata   = !we ? '0
                      : f3_q[1] ? data_q
                      : f3_q[0] ? {2{data_q[15:0]}}
                                : {4{data_q[7:0]}};
  assign M_valid_o  = state == DONE;
  assign M_valM_o   = val_q;
  assign M_rd_o     = rd_q;
  assign M_rd_wen_o = wen_q;
  assign M_PC_o     = pc_q;
  assign M_exc_o    = exc_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage with a memory responder
module tb_mem_stage;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic E_valid = 0, E_load = 0, E_store = 0, E_rd_wen = 0, M_ready = 0;
  logic [31:0] E_valE = 0, E_sdata = 0, E_pc = 0;
  logic [2:0] E_f3 = 0;
  logic [4:0] E_rd = 0;
  logic E_ready, M_valid, M_rd_wen, M_exc;
  logic [31:0] M_valM, M_pc;
  logic [4:0] M_rd;
  mem_stage_if #(.XLEN(32)) bus();
  mem_stage #(.XLEN(32), .PC_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .E_valid_i(E_valid), .E_ready_o(E_ready), .E_valE_i(E_valE), .E_store_data_i(E_sdata),
    .E_load_i(E_load), .E_store_i(E_store), .E_funct3_i(E_f3), .E_rd_i(E_rd),
    .E_rd_wen_i(E_rd_wen), .E_PC_i(E_pc), .dmem(bus),
    .M_valid_o(M_valid), .M_ready_i(M_ready), .M_valM_o(M_valM), .M_rd_o(M_rd),
    .M_rd_wen_o(M_rd_wen), .M_PC_o(M_pc), .M_exc_o(M_exc)
  );
  typedef struct {
    logic [31:0] val;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] pc;
    logic        exc;
    int          due;
  } m_t;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gd;
    int          rdl;
  } r_t;
  m_t mq[$];
  r_t rq[$];
  int cyc = 0, checks = 0, errors = 0;
  bit idle_chk = 0, done = 0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  task automatic push_m(input logic [31:0] v, input logic [4:0] rd, input logic wen,
                        input logic [31:0] pc, input logic exc, input int due);
    m_t m;
    m.val = v; m.rd = rd; m.wen = wen; m.pc = pc; m.exc = exc; m.due = due;
    mq.push_back(m);
  endtask
  task automatic push_r(input logic we, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd, input logic [31:0] rd, input int gd, input int rdl);
    r_t r;
    r.we = we; r.addr = a; r.be = be; r.wdata = wd; r.rdata = rd; r.gd = gd; r.rdl = rdl;
    rq.push_back(r);
  endtask
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] rd, input logic [31:0] pc);
    int n = 0;
    bit acc;
    E_valid = 1; E_load = ld; E_store = st; E_f3 = f3; E_valE = a; E_sdata = d;
    E_rd = rd; E_rd_wen = 1; E_pc = pc;
    do begin
      @(negedge clk);
      acc = E_ready;
      @(posedge clk); #1;
      n++;
      if (n > 50) begin
        $display("FAIL issue: op at pc %h never accepted", pc);
        $fatal(1);
      end
    end while (!acc);
    E_valid = 0; E_load = 0; E_store = 0;
  endtask
  task automatic op_alu(input logic [31:0] v, input logic [4:0] rd, input logic [31:0] pc);
    push_m(v, rd, 1, pc, 0, cyc + 2);
    issue(0, 0, 3'b000, v, 32'h0, rd, pc);
  endtask
  task automatic op_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] waddr,
                         input logic [31:0] rdata, input logic [31:0] exp, input logic [4:0] rd,
                         input logic [31:0] pc, input int gd, input int rdl);
    push_r(0, waddr, 4'b0000, 32'h0, rdata, gd, rdl);
    push_m(exp, rd, 1, pc, 0, -1);
    issue(1, 0, f3, a, 32'h0, rd, pc);
  endtask
  task automatic op_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] waddr, input logic [3:0] be, input logic [31:0] wd,
                          input logic [31:0] pc);
    push_r(1, waddr, be, wd, 32'h0, 0, 0);
    push_m(a, 5'd7, 0, pc, 0, -1);
    issue(0, 1, f3, a, d, 5'd7, pc);
  endtask
  task automatic op_exc(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] pc);
    push_m(a, 5'd9, 0, pc, 1, cyc + 2);
    issue(ld, st, f3, a, 32'h5555_5555, 5'd9, pc);
  endtask
  task automatic drain;
    int n = 0;
    while (mq.size() != 0) begin
      @(posedge clk); #1;
      n++;
      if (n > 100) begin
        $display("FAIL drain: %0d results never delivered", mq.size());
        $fatal(1);
      end
    end
  endtask
  // stimulus
  initial begin
    int n;
    idle_chk = 1; M_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    repeat (2) @(posedge clk);
    #1 idle_chk = 0;
    op_alu(32'h1234_5678, 5'd5, 32'h100);
    op_alu(32'hFFFF_FFFF, 5'd6, 32'h104);
    op_alu(32'h0000_0001, 5'd7, 32'h108);
    op_load(3'b000, 32'h1003, 32'h1000, 32'h80FF_0000, 32'hFFFF_FF80, 5'd1, 32'h200, 0, 0);
    op_load(3'b100, 32'h1003, 32'h1000, 32'h80FF_0000, 32'h0000_0080, 5'd2, 32'h204, 0, 0);
    op_load(3'b001, 32'h1002, 32'h1000, 32'h80FF_0000, 32'hFFFF_80FF, 5'd3, 32'h208, 0, 0);
    op_load(3'b101, 32'h1002, 32'h1000, 32'h80FF_0000, 32'h0000_80FF, 5'd4, 32'h20C, 0, 0);
    op_load(3'b000, 32'h1001, 32'h1000, 32'h1234_5678, 32'h0000_0056, 5'd8, 32'h210, 1, 0);
    op_load(3'b010, 32'h1008, 32'h1008, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5'd9, 32'h214, 0, 2);
    op_store(3'b001, 32'h2002, 32'hAAAA_BEEF, 32'h2000, 4'b1100, 32'hBEEF_BEEF, 32'h300);
    op_store(3'b000, 32'h2001, 32'h1234_56AB, 32'h2000, 4'b0010, 32'hABAB_ABAB, 32'h304);
    op_store(3'b010, 32'h2004, 32'hCAFE_F00D, 32'h2004, 4'b1111, 32'hCAFE_F00D, 32'h308);
    drain;
    op_exc(1, 0, 3'b010, 32'h3001, 32'h400);
    op_exc(0, 1, 3'b001, 32'h3003, 32'h404);
    op_exc(1, 0, 3'b001, 32'h3001, 32'h408);
    op_exc(1, 0, 3'b011, 32'h3000, 32'h40C);
    op_exc(0, 1, 3'b100, 32'h3000, 32'h410);
    op_exc(1, 1, 3'b010, 32'h3000, 32'h414);
    drain;
    M_ready = 0;
    op_load(3'b010, 32'h4000, 32'h4000, 32'h0BAD_F00D, 32'h0BAD_F00D, 5'd3, 32'h500, 3, 1);
    n = 0;
    while (!M_valid) begin
      @(negedge clk);
      n++;
      if (n > 50) begin
        $display("FAIL stall load: M_valid never rose");
        $fatal(1);
      end
    end
    repeat (2) @(posedge clk);
    #1 M_ready = 1;
    drain;
    push_r(0, 32'h5000, 4'b0000, 32'h0, 32'h1111_1111, 0, 4);
    issue(1, 0, 3'b010, 32'h5000, 32'h0, 5'd10, 32'h600);
    @(posedge clk);
    #2 rst_n = 0; idle_chk = 1;
    @(posedge clk);
    #3 rst_n = 1;
    repeat (8) @(posedge clk);
    #1 idle_chk = 0;
    op_alu(32'h55AA_55AA, 5'd11, 32'h700);
    drain;
    done = 1;
  end
  // memory responder + scoreboard monitor
  initial begin
    r_t cr;
    m_t cm, held;
    int wcnt = 0, rcnt = 0;
    bit rpend = 0, have = 0, stall = 0;
    logic [31:0] a0 = 0, w0 = 0;
    logic [3:0] b0 = 0;
    logic we0 = 0;
    bus.gnt = 0; bus.rvalid = 0; bus.rdata = 0;
    forever begin
      @(negedge clk);
      cyc++;
      bus.gnt = 0; bus.rvalid = 0;
      if (idle_chk) begin
        chk("idle M_valid", 32'(M_valid), 32'd0);
        chk("idle E_ready", 32'(E_ready), 32'd1);
        chk("idle dmem_req", 32'(bus.req), 32'd0);
        chk("idle M_valM", M_valM, 32'd0);
      end
      if (rpend) begin
        if (rcnt == 0) begin
          bus.rvalid = 1; bus.rdata = cr.rdata; rpend = 0;
        end else rcnt--;
      end else if (bus.req) begin
        if (!have) begin
          chk("dmem_req expected", 32'(rq.size() != 0), 32'd1);
          if (rq.size() != 0) cr = rq.pop_front();
          else begin
            cr.we = bus.we; cr.addr = bus.addr; cr.be = bus.be; cr.wdata = bus.wdata;
            cr.rdata = 0; cr.gd = 0; cr.rdl = 0;
          end
          have = 1; wcnt = 0;
          a0 = bus.addr; w0 = bus.wdata; b0 = bus.be; we0 = bus.we;
        end else begin
          chk("dmem_addr stable", bus.addr, a0);
          chk("dmem_wdata stable", bus.wdata, w0);
          chk("dmem_be stable", 32'(bus.be), 32'(b0));
          chk("dmem_we stable", 32'(bus.we), 32'(we0));
        end
        if (wcnt == cr.gd) begin
          chk("dmem_we", 32'(bus.we), 32'(cr.we));
          chk("dmem_addr", bus.addr, cr.addr);
          chk("dmem_be", 32'(bus.be), 32'(cr.be));
          chk("dmem_wdata", bus.wdata, cr.wdata);
          bus.gnt = 1; have = 0;
          if (!cr.we) begin rpend = 1; rcnt = cr.rdl; end
        end else wcnt++;
      end else if (have) begin
        chk("dmem_req held until gnt", 32'(bus.req), 32'd1);
        have = 0;
      end
      if (stall) begin
        chk("M_valid held", 32'(M_valid), 32'd1);
        chk("M_valM held", M_valM, held.val);
        chk("M_rd held", 32'(M_rd), 32'(held.rd));
        chk("M_PC held", M_pc, held.pc);
        chk("M_exc held", 32'(M_exc), 32'(held.exc));
      end
      if (M_valid && M_ready) begin
        chk("M handshake expected", 32'(mq.size() != 0), 32'd1);
        if (mq.size() != 0) begin
          cm = mq.pop_front();
          chk("M_valM", M_valM, cm.val);
          chk("M_rd", 32'(M_rd), 32'(cm.rd));
          chk("M_rd_wen", 32'(M_rd_wen), 32'(cm.wen));
          chk("M_PC", M_pc, cm.pc);
          chk("M_exc", 32'(M_exc), 32'(cm.exc));
          if (cm.due >= 0) chk("M latency cycle", cyc, cm.due);
        end
      end
      stall = M_valid && !M_ready;
      held.val = M_valM; held.rd = M_rd; held.wen = M_rd_wen; held.pc = M_pc; held.exc = M_exc;
      if (done) begin
        chk("results drained", mq.size(), 32'd0);
        chk("requests drained", rq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
